pu_issue_ctrl: RTL and testbench
================================

PU_ISSUE_CTRL -- requirements
Module: pu_issue_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter TIMEOUT, default 64, cycles allowed in WAIT before abort (TIMEOUT_EN builds only).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1  host operand handshake.
REQ-006 SHALL have ports in_a input 16, in_b input 16  FP16 operand pair.
REQ-007 SHALL have ports pu_en output 1, pu_a output 16, pu_b output 16  drive to processing unit.
REQ-008 SHALL have ports pu_p input 16, pu_ready input 1  processing unit result and completion.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_p output 16  result handshake.
REQ-010 SHALL have port err output 1  one-cycle timeout pulse; tied 0 without TIMEOUT_EN.

Function
REQ-011 SHALL push {in_a,in_b} into the FIFO on a cycle where in_valid and in_ready are both high.
REQ-012 SHALL drive in_ready = FIFO not full; a simultaneous push and pop on a full FIFO is not accepted (in_ready already low).
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT, HOLD; reset state IDLE.
REQ-014 IDLE -> ISSUE when FIFO not empty: pop head into pu_a/pu_b registers at that edge.
REQ-015 ISSUE: pu_en=1 for one cycle with stable pu_a/pu_b, then -> WAIT.
REQ-016 WAIT: pu_en held 1, pu_a/pu_b held stable; on pu_ready=1 capture pu_p into out_p, drop pu_en next cycle, -> HOLD.
REQ-017 pu_ready outside WAIT SHALL be ignored.
REQ-018 HOLD: out_valid=1, out_p stable until out_valid && out_ready; then -> IDLE, or -> ISSUE directly (pop at same edge) if FIFO not empty.
REQ-019 Push during any state SHALL proceed independently of the FSM; push into empty FIFO while in IDLE is issued the following cycle.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-021 Operands SHALL be passed bit-exact; no arithmetic on FP16 values.
REQ-022 Latency in_valid accept (empty FIFO, IDLE) to pu_en high SHALL be 2 cycles.

Reset
REQ-023 reset low at a rising edge SHALL force IDLE, FIFO empty, pu_en=0, pu_a=pu_b=0, out_valid=0, out_p=0, err=0, timeout counter 0.
REQ-024 Reset mid-transaction SHALL discard FIFO contents and any in-flight result; in_ready=1 on the first cycle after reset releases.

Configuration
REQ-025 Macro TIMEOUT_EN defined: counter increments each WAIT cycle; reaching TIMEOUT without pu_ready SHALL pulse err, load out_p=16'h7E00 (qNaN), -> HOLD.
REQ-026 TIMEOUT_EN undefined: no counter, WAIT persists until pu_ready, err constant 0.

Verification
REQ-027 After reset, push (4400,4600); PU model ready after 3 cycles with P=4A00 -> pu_en high 2 cycles after push, out_valid with out_p=4A00, pu_en low after ready.
REQ-028 Push 4 pairs back-to-back with out_ready=0 -> in_ready low after 4th push (DEPTH=4); 5th push refused; all pairs later issued in order.
REQ-029 Hold out_ready=0 for 10 cycles in HOLD -> out_p stable, no new pu_en; release -> next pair issued at the same edge.
REQ-030 Assert reset in WAIT with 2 pairs queued -> all outputs at reset values, no result emitted, queue empty.
REQ-031 TIMEOUT_EN, TIMEOUT=64, pu_ready never asserted for (4000,C400) -> err pulse at 64th WAIT cycle, out_p=7E00.
REQ-032 Spurious pu_ready in IDLE/HOLD -> no state change, out_p unchanged.

Source files
------------

// File: rtl/pu_issue_ctrl_if.sv
// pu_issue_ctrl_if: host operand, processing-unit and result handshakes
// bundled for pu_issue_ctrl. master = environment, slave = controller.
interface pu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        pu_en;
  logic [15:0] pu_a;
  logic [15:0] pu_b;
  logic [15:0] pu_p;
  logic        pu_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        err;

  modport master (
    output in_valid, in_a, in_b, pu_p, pu_ready, out_ready,
    input  in_ready, pu_en, pu_a, pu_b, out_valid, out_p, err
  );

  modport slave (
    input  in_valid, in_a, in_b, pu_p, pu_ready, out_ready,
    output in_ready, pu_en, pu_a, pu_b, out_valid, out_p, err
  );
endinterface

// File: rtl/pu_issue_ctrl.sv
// pu_issue_ctrl: buffers FP16 operand pairs in a small FIFO and issues them
// one at a time to a processing unit, returning each result over a
// valid/ready handshake. Operands and results pass through bit-exact.
// Optional macro TIMEOUT_EN: abort a WAIT that lasts TIMEOUT cycles, pulse
// err and return qNaN (16'h7E00) as the result.
module pu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  pu_issue_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  // reject configurations the pointer arithmetic cannot support
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("pu_issue_ctrl: DEPTH must be a power of two >= 2, TIMEOUT >= 1");
  end

  state_t          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     pu_a_q, pu_a_d;
  logic [15:0]     pu_b_q, pu_b_d;
  logic [15:0]     out_p_q, out_p_d;
  logic            push, pop, empty, full;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tmo_hit;
`endif

  assign full          = (cnt_q == CW'(DEPTH));
  assign empty         = (cnt_q == '0);
  assign bus.in_ready  = !full;
  assign push          = bus.in_valid && !full;
  assign bus.pu_en     = (state_q == ISSUE) || (state_q == WAIT);
  assign bus.pu_a      = pu_a_q;
  assign bus.pu_b      = pu_b_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_p     = out_p_q;
`ifdef TIMEOUT_EN
  assign bus.err       = tmo_hit;
`else
  assign bus.err       = 1'b0;
`endif

  // issue FSM: pops the FIFO head into the PU operand registers
  always_comb begin
    state_d = state_q;
    pu_a_d  = pu_a_q;
    pu_b_d  = pu_b_q;
    out_p_d = out_p_q;
    pop     = 1'b0;
`ifdef TIMEOUT_EN
    tmo_d   = '0;
    tmo_hit = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.pu_ready) begin
          out_p_d = bus.pu_p;
          state_d = HOLD;
        end
`ifdef TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          out_p_d = 16'h7E00;
          state_d = HOLD;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) {pu_a_d, pu_b_d} = mem_q[rd_ptr_q];
  end

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage; contents are don't-care once the occupancy resets
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
  end

  // state and control registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      pu_a_q   <= '0;
      pu_b_q   <= '0;
      out_p_q  <= '0;
`ifdef TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      pu_a_q   <= pu_a_d;
      pu_b_q   <= pu_b_d;
      out_p_q  <= out_p_d;
`ifdef TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end
endmodule

// File: tb/tb_pu_issue_ctrl.sv
// tb_pu_issue_ctrl: scoreboard bench. Each pushed pair queues its expected
// operands (checked by the PU model at issue) and its expected result
// (checked by the output monitor on each out handshake).
module tb_pu_issue_ctrl;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic [3:0]  lat;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pu_issue_ctrl_if bus ();

  logic        m_rdy = 1'b0, spur_rdy = 1'b0, sink_rdy = 1'b0;
  logic [15:0] m_p = '0;
  bit          rnd_sink = 1'b0, err_ok = 1'b0;

  assign bus.pu_ready  = m_rdy | spur_rdy;
  assign bus.pu_p      = spur_rdy ? 16'hDEAD : m_p;
  assign bus.out_ready = sink_rdy;

  pu_issue_ctrl #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  op_t         op_q[$];
  logic [15:0] exp_q[$];
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] p, input int lat);
    op_t o;
    int  g = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!bus.in_ready && g < 200) begin
      tick();
      g++;
    end
    if (!bus.in_ready) begin
      chk("push_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    o.a = a; o.b = b; o.p = p; o.lat = 4'(lat);
    op_q.push_back(o);
    exp_q.push_back(p);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || bus.out_valid || bus.pu_en) && g < 600) begin
      tick();
      g++;
    end
    chk("drain", {exp_q.size() == 0, bus.out_valid, bus.pu_en}, 3'b100);
  endtask

  task automatic wait_ov();
    int g = 0;
    while (!bus.out_valid && g < 50) begin
      tick();
      g++;
    end
    chk("wait_ov", bus.out_valid, 1);
  endtask

  // PU model: checks operands on issue, raises pu_ready after op.lat cycles
  initial begin : pu_model
    int  wcnt = 0;
    op_t cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.pu_en) begin
        m_rdy = 1'b0;
        wcnt  = 0;
      end else begin
        if (wcnt == 0) begin
          if (op_q.size() == 0) begin
            chk("issue_unexpected", 1, 0);
            cur = '0;
            cur.lat = 4'd2;
          end else begin
            cur = op_q.pop_front();
          end
        end
        chk("pu_ab", {bus.pu_a, bus.pu_b}, {cur.a, cur.b});
        wcnt++;
        m_rdy = (cur.lat != 0) && (wcnt == int'(cur.lat));
        m_p   = cur.p;
      end
    end
  end

  // output monitor: each completed result handshake pops the scoreboard
  initial begin : out_mon
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
        else                   chk("out_p", bus.out_p, exp_q.pop_front());
      end
      if (rst_n && bus.err && !err_ok) chk("err_spurious", bus.err, 0);
    end
  end

  // random result back-pressure
  initial begin : sink_rnd
    forever begin
      @(posedge clk);
      #1;
      if (rnd_sink) sink_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    tick(3);
    // reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_pu_en", bus.pu_en, 0);
    chk("rst_pu_a", bus.pu_a, 0);
    chk("rst_pu_b", bus.pu_b, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_p", bus.out_p, 0);
    chk("rst_err", bus.err, 0);
    rst_n    = 1'b1;
    sink_rdy = 1'b1;

    // single transaction, latency to pu_en
    push(16'h4400, 16'h4600, 16'h4A00, 3);
    chk("lat_1cyc", bus.pu_en, 0);
    tick();
    chk("lat_2cyc", bus.pu_en, 1);
    wait_ov();
    chk("t1_pu_en_off", bus.pu_en, 0);
    chk("t1_out_p", bus.out_p, 16'h4A00);
    drain();

    // fill FIFO behind a held result
    sink_rdy = 1'b0;
    push(16'h3C00, 16'hBC00, 16'h1111, 2);
    wait_ov();
    for (int i = 0; i < 4; i++)
      push(16'h4000 + 16'(i), 16'h5000 + 16'(i), 16'h2000 + 16'(i), 2 + i);
    chk("full_in_ready", bus.in_ready, 0);
    // HOLD with back-pressure and a spurious pu_ready
    for (int i = 0; i < 10; i++) begin
      spur_rdy = (i >= 3 && i < 6);
      tick();
      chk("hold_out_p", bus.out_p, 16'h1111);
      chk("hold_pu_en", bus.pu_en, 0);
    end
    spur_rdy = 1'b0;
    // fifth pair must be refused
    bus.in_valid = 1'b1;
    bus.in_a     = 16'hBAD0;
    bus.in_b     = 16'hBAD1;
    tick();
    chk("refuse_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    sink_rdy = 1'b1;
    tick();
    chk("hold_to_issue", bus.pu_en, 1);
    chk("hold_to_issue_a", bus.pu_a, 16'h4000);
    drain();

    // spurious pu_ready in IDLE
    for (int i = 0; i < 3; i++) begin
      spur_rdy = 1'b1;
      tick();
      chk("idle_spur", {bus.out_valid, bus.pu_en, bus.out_p}, {2'b00, 16'h2003});
    end
    spur_rdy = 1'b0;
    tick();

    // random operands, latencies and back-pressure
    rnd_sink = 1'b1;
    for (int i = 0; i < 8; i++)
      push(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(2, 6)));
    drain();
    rnd_sink = 1'b0;
    sink_rdy = 1'b1;

    // reset during WAIT with two pairs queued
    push(16'h4100, 16'h4200, 16'h0001, 15);
    push(16'h4300, 16'h4400, 16'h0002, 15);
    push(16'h4500, 16'h4600, 16'h0003, 15);
    tick(2);
    chk("pre_rst_wait", bus.pu_en, 1);
    rst_n = 1'b0;
    op_q.delete();
    exp_q.delete();
    tick();
    chk("mid_rst_outs", {bus.pu_en, bus.out_valid, bus.err, bus.pu_a, bus.pu_b},
        {3'b000, 32'h0});
    chk("mid_rst_out_p", bus.out_p, 0);
    rst_n = 1'b1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    begin
      logic any_act = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        any_act |= bus.pu_en | bus.out_valid;
      end
      chk("post_rst_quiet", any_act, 0);
    end

`ifdef TIMEOUT_EN
    // PU never answers: abort on the 64th WAIT cycle with qNaN
    begin
      int ne = 0, ecyc = -1;
      err_ok = 1'b1;
      push(16'h4000, 16'hC400, 16'h7E00, 0);
      for (int g = 0; g < 200 && ecyc < 0; g++) begin
        tick();
        if (bus.pu_en) ne++;
        if (bus.err) ecyc = ne;
      end
      chk("tmo_err_cycle", 32'(ecyc), 32'd65);
      tick();
      chk("tmo_err_pulse", bus.err, 0);
      chk("tmo_out_p", bus.out_p, 16'h7E00);
      drain();
      err_ok = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
